slurm16_cpu_scoreboard: RTL and testbench

Parametrised register/flag scoreboard for the slurm16 pipeline. It replaces fixed three-slot hazard detection with a depth-configurable in-flight tracking shift register. It takes pre-decoded issue information from the decode stage. It produces a stall request, per-stage hazard flags, per-operand forwarding selects, and an in-flight count, with optional forwarding and a configurable load-result latency.

---
 rtl/slurm16_cpu_scoreboard.sv | 145 ++++++++++++++
 tb/tb_slurm16_cpu_scoreboard.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slurm16_cpu_scoreboard.sv
// slurm16_cpu_scoreboard
// In-flight register/flag scoreboard for the slurm16 pipeline. Tracks DEPTH
// issued instructions in a shift register (s[1] youngest at index 0) and
// decides, in the same cycle as the decode inputs, whether the decode slot
// must stall and which stage each source operand should be forwarded from.

module slurm16_cpu_scoreboard #(
  parameter int BITS          = 16,
  parameter int REGISTER_BITS = 4,
  parameter int DEPTH         = 3,
  parameter int FORWARD       = 1,
  parameter int LOAD_LATENCY  = 2,
  localparam int SW           = $clog2(DEPTH + 1)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     issue_valid,
  input  logic [REGISTER_BITS-1:0] issue_dest,
  input  logic                     issue_modifies_flags,
  input  logic                     issue_is_load,
  input  logic [REGISTER_BITS-1:0] regA_sel,
  input  logic [REGISTER_BITS-1:0] regB_sel,
  input  logic                     uses_flags,
  input  logic                     hold_in,
  input  logic                     flush_in,
  output logic                     stall_out,
  output logic [DEPTH-1:0]         hazard_vec,
  output logic [SW-1:0]            fwdA_stage,
  output logic [SW-1:0]            fwdB_stage,
  output logic [SW-1:0]            occupancy
);

  // Reject parameter sets the shift/forward logic was not built for.
  if (BITS < 1 || REGISTER_BITS < 1 || DEPTH < 2 || DEPTH > 8 ||
      LOAD_LATENCY < 1 || LOAD_LATENCY > DEPTH) begin : g_param_check
    $error("slurm16_cpu_scoreboard: unsupported parameter set");
  end

  // Tracked entries, index k-1 holds stage s[k].
  logic [DEPTH-1:0]                    valid_q, valid_d;
  logic [DEPTH-1:0][REGISTER_BITS-1:0] dest_q, dest_d;
  logic [DEPTH-1:0]                    mod_flags_q, mod_flags_d;
  logic [DEPTH-1:0]                    is_load_q, is_load_d;
  logic [SW-1:0]                       occupancy_q, occupancy_d;

  // Per-stage match information.
  logic [DEPTH-1:0] match_a;
  logic [DEPTH-1:0] match_b;
  logic [DEPTH-1:0] flag_match;
  logic [DEPTH-1:0] ready_stage;

  // Youngest-match selection per operand.
  logic          found_a, found_b;
  logic          ready_a, ready_b;
  logic [SW-1:0] sel_a, sel_b;

  logic stall;
  logic insert_valid;

  // Compare both source operands and the flag use against every tracked stage.
  always_comb begin
    match_a     = '0;
    match_b     = '0;
    flag_match  = '0;
    ready_stage = '0;
    for (int k = 0; k < DEPTH; k++) begin
      match_a[k]     = valid_q[k] && (regA_sel != '0) && (regA_sel == dest_q[k]);
      match_b[k]     = valid_q[k] && (regB_sel != '0) && (regB_sel == dest_q[k]);
      flag_match[k]  = uses_flags && valid_q[k] && mod_flags_q[k];
      ready_stage[k] = (FORWARD != 0) && (!is_load_q[k] || ((k + 1) >= LOAD_LATENCY));
    end
  end

  // Pick the youngest producer per operand; walking oldest-to-youngest lets
  // the youngest match overwrite any older one.
  always_comb begin
    found_a = 1'b0;
    found_b = 1'b0;
    ready_a = 1'b0;
    ready_b = 1'b0;
    sel_a   = '0;
    sel_b   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match_a[k]) begin
        found_a = 1'b1;
        ready_a = ready_stage[k];
        sel_a   = SW'(k + 1);
      end
      if (match_b[k]) begin
        found_b = 1'b1;
        ready_b = ready_stage[k];
        sel_b   = SW'(k + 1);
      end
    end
  end

  // Stall/forward decision; flags are never forwarded so any flag match stalls.
  always_comb begin
    stall = issue_valid &&
            ((found_a && !ready_a) || (found_b && !ready_b) || (|flag_match));
    stall_out  = stall;
    hazard_vec = issue_valid ? (match_a | match_b | flag_match) : '0;
    fwdA_stage = (!stall && found_a && ready_a) ? sel_a : '0;
    fwdB_stage = (!stall && found_b && ready_b) ? sel_b : '0;
    occupancy  = occupancy_q;
  end

  // Next-state: flush beats hold, hold beats stall, stall inserts a bubble.
  always_comb begin
    insert_valid = issue_valid && !stall;
    valid_d      = valid_q;
    dest_d       = dest_q;
    mod_flags_d  = mod_flags_q;
    is_load_d    = is_load_q;
    occupancy_d  = occupancy_q;
    if (flush_in) begin
      valid_d     = '0;
      occupancy_d = '0;
    end else if (!hold_in) begin
      valid_d     = {valid_q[DEPTH-2:0], insert_valid};
      dest_d      = {dest_q[DEPTH-2:0], (insert_valid ? issue_dest : {REGISTER_BITS{1'b0}})};
      mod_flags_d = {mod_flags_q[DEPTH-2:0], (insert_valid && issue_modifies_flags)};
      is_load_d   = {is_load_q[DEPTH-2:0], (insert_valid && issue_is_load)};
      occupancy_d = occupancy_q + SW'(insert_valid) - SW'(valid_q[DEPTH-1]);
    end
  end

  // Entry and occupancy registers; reset empties the scoreboard immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q     <= '0;
      dest_q      <= '0;
      mod_flags_q <= '0;
      is_load_q   <= '0;
      occupancy_q <= '0;
    end else begin
      valid_q     <= valid_d;
      dest_q      <= dest_d;
      mod_flags_q <= mod_flags_d;
      is_load_q   <= is_load_d;
      occupancy_q <= occupancy_d;
    end
  end

endmodule

// File: tb/tb_slurm16_cpu_scoreboard.sv
// Testbench for slurm16_cpu_scoreboard: one forwarding instance (defaults) and
// one FORWARD=0 instance share the same stimulus. Each scenario queues
// stimulus rows with hand-derived expected outputs, then replays them.

module tb_slurm16_cpu_scoreboard;

  logic       CLK = 1'b0;
  logic       RST;
  logic       issue_valid;
  logic [3:0] issue_dest;
  logic       issue_modifies_flags;
  logic       issue_is_load;
  logic [3:0] regA_sel;
  logic [3:0] regB_sel;
  logic       uses_flags;
  logic       hold_in;
  logic       flush_in;

  logic       stall_m, stall_n;
  logic [2:0] hazard_m, hazard_n;
  logic [1:0] fwda_m, fwda_n;
  logic [1:0] fwdb_m, fwdb_n;
  logic [1:0] occ_m, occ_n;

  typedef struct packed {
    logic       v;
    logic [3:0] d;
    logic       mf;
    logic       ld;
    logic [3:0] a;
    logic [3:0] b;
    logic       uf;
    logic       hold;
    logic       flush;
  } stim_t;

  typedef struct packed {
    logic       stall;
    logic [2:0] hz;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [1:0] occ;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 CLK = ~CLK;

  slurm16_cpu_scoreboard u_dut (
    .CLK(CLK), .RST(RST),
    .issue_valid(issue_valid), .issue_dest(issue_dest),
    .issue_modifies_flags(issue_modifies_flags), .issue_is_load(issue_is_load),
    .regA_sel(regA_sel), .regB_sel(regB_sel), .uses_flags(uses_flags),
    .hold_in(hold_in), .flush_in(flush_in),
    .stall_out(stall_m), .hazard_vec(hazard_m),
    .fwdA_stage(fwda_m), .fwdB_stage(fwdb_m), .occupancy(occ_m)
  );

  slurm16_cpu_scoreboard #(.FORWARD(0)) u_dut_nf (
    .CLK(CLK), .RST(RST),
    .issue_valid(issue_valid), .issue_dest(issue_dest),
    .issue_modifies_flags(issue_modifies_flags), .issue_is_load(issue_is_load),
    .regA_sel(regA_sel), .regB_sel(regB_sel), .uses_flags(uses_flags),
    .hold_in(hold_in), .flush_in(flush_in),
    .stall_out(stall_n), .hazard_vec(hazard_n),
    .fwdA_stage(fwda_n), .fwdB_stage(fwdb_n), .occupancy(occ_n)
  );

  // Queue one stimulus row and the outputs expected while it is applied.
  task automatic add(input int v, input int d, input int mf, input int ld,
                     input int a, input int b, input int uf, input int hold,
                     input int flush, input int st, input int hz, input int fa,
                     input int fb, input int occ);
    stim_t s;
    exp_t  e;
    s.v = v[0]; s.d = 4'(d); s.mf = mf[0]; s.ld = ld[0];
    s.a = 4'(a); s.b = 4'(b); s.uf = uf[0]; s.hold = hold[0]; s.flush = flush[0];
    e.stall = st[0]; e.hz = 3'(hz); e.fa = 2'(fa); e.fb = 2'(fb); e.occ = 2'(occ);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    issue_valid          = s.v;
    issue_dest           = s.d;
    issue_modifies_flags = s.mf;
    issue_is_load        = s.ld;
    regA_sel             = s.a;
    regB_sel             = s.b;
    uses_flags           = s.uf;
    hold_in              = s.hold;
    flush_in             = s.flush;
  endtask

  task automatic drive_idle();
    stim_t s;
    s = '0;
    drive(s);
  endtask

  // Clear both instances; returns 1 time unit after a rising edge.
  task automatic do_reset();
    drive_idle();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    drive_idle();
    RST = 1'b1;
    add(0,0,0,0,0,0,0,0,0, 0,3'b000,0,0,0);
    void'(stim_q.pop_front());
    @(negedge CLK);
    e = exp_q.pop_front();
    checks++; if (stall_m !== e.stall) begin errors++; $display("[TB] FAIL reset stall got %b want %b", stall_m, e.stall); end
    checks++; if (hazard_m !== e.hz) begin errors++; $display("[TB] FAIL reset hazard got %b want %b", hazard_m, e.hz); end
    checks++; if (fwda_m !== e.fa) begin errors++; $display("[TB] FAIL reset fwdA got %0d want %0d", fwda_m, e.fa); end
    checks++; if (fwdb_m !== e.fb) begin errors++; $display("[TB] FAIL reset fwdB got %0d want %0d", fwdb_m, e.fb); end
    checks++; if (occ_m !== e.occ) begin errors++; $display("[TB] FAIL reset occupancy got %0d want %0d", occ_m, e.occ); end
    checks++; if (occ_n !== e.occ) begin errors++; $display("[TB] FAIL reset nf occupancy got %0d want %0d", occ_n, e.occ); end
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_forward();
    exp_t e;
    int   cyc = 0;
    do_reset();
    add(1,3,0,0,0,0,0,0,0, 0,3'b000,0,0,0);
    add(1,0,0,0,3,0,0,0,0, 0,3'b001,1,0,1);
    add(0,0,0,0,0,0,0,0,0, 0,3'b000,0,0,2);
    add(0,0,0,0,0,0,0,0,0, 0,3'b000,0,0,2);
    add(0,0,0,0,0,0,0,0,0, 0,3'b000,0,0,1);
    add(0,0,0,0,0,0,0,0,0, 0,3'b000,0,0,0);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++; if (stall_m !== e.stall) begin errors++; $display("[TB] FAIL forward c%0d stall got %b want %b", cyc, stall_m, e.stall); end
      checks++; if (hazard_m !== e.hz) begin errors++; $display("[TB] FAIL forward c%0d hazard got %b want %b", cyc, hazard_m, e.hz); end
      checks++; if (fwda_m !== e.fa) begin errors++; $display("[TB] FAIL forward c%0d fwdA got %0d want %0d", cyc, fwda_m, e.fa); end
      checks++; if (fwdb_m !== e.fb) begin errors++; $display("[TB] FAIL forward c%0d fwdB got %0d want %0d", cyc, fwdb_m, e.fb); end
      checks++; if (occ_m !== e.occ) begin errors++; $display("[TB] FAIL forward c%0d occupancy got %0d want %0d", cyc, occ_m, e.occ); end
      @(posedge CLK);
      #1;
      cyc++;
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    int   cyc = 0;
    do_reset();
    add(1,5,0,1,0,0,0,0,0, 0,3'b000,0,0,0);
    add(1,0,0,0,5,0,0,0,0, 1,3'b001,0,0,1);
    add(1,0,0,0,5,0,0,0,0, 0,3'b010,2,0,1);
    add(0,0,0,0,0,0,0,0,0, 0,3'b000,0,0,2);
    add(0,0,0,0,0,0,0,0,0, 0,3'b000,0,0,1);
    add(0,0,0,0,0,0,0,0,0, 0,3'b000,0,0,1);
    add(0,0,0,0,0,0,0,0,0, 0,3'b000,0,0,0);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++; if (stall_m !== e.stall) begin errors++; $display("[TB] FAIL load_use c%0d stall got %b want %b", cyc, stall_m, e.stall); end
      checks++; if (hazard_m !== e.hz) begin errors++; $display("[TB] FAIL load_use c%0d hazard got %b want %b", cyc, hazard_m, e.hz); end
      checks++; if (fwda_m !== e.fa) begin errors++; $display("[TB] FAIL load_use c%0d fwdA got %0d want %0d", cyc, fwda_m, e.fa); end
      checks++; if (fwdb_m !== e.fb) begin errors++; $display("[TB] FAIL load_use c%0d fwdB got %0d want %0d", cyc, fwdb_m, e.fb); end
      checks++; if (occ_m !== e.occ) begin errors++; $display("[TB] FAIL load_use c%0d occupancy got %0d want %0d", cyc, occ_m, e.occ); end
      @(posedge CLK);
      #1;
      cyc++;
    end
  endtask

  task automatic test_no_forward();
    exp_t e;
    int   cyc = 0;
    do_reset();
    add(1,4,0,0,0,0,0,0,0, 0,3'b000,0,0,0);
    add(1,0,0,0,4,0,0,0,0, 1,3'b001,0,0,1);
    add(1,0,0,0,4,0,0,0,0, 1,3'b010,0,0,1);
    add(1,0,0,0,4,0,0,0,0, 1,3'b100,0,0,1);
    add(1,0,0,0,4,0,0,0,0, 0,3'b000,0,0,0);
    add(0,0,0,0,0,0,0,0,0, 0,3'b000,0,0,1);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++; if (stall_n !== e.stall) begin errors++; $display("[TB] FAIL no_forward c%0d stall got %b want %b", cyc, stall_n, e.stall); end
      checks++; if (hazard_n !== e.hz) begin errors++; $display("[TB] FAIL no_forward c%0d hazard got %b want %b", cyc, hazard_n, e.hz); end
      checks++; if (fwda_n !== e.fa) begin errors++; $display("[TB] FAIL no_forward c%0d fwdA got %0d want %0d", cyc, fwda_n, e.fa); end
      checks++; if (fwdb_n !== e.fb) begin errors++; $display("[TB] FAIL no_forward c%0d fwdB got %0d want %0d", cyc, fwdb_n, e.fb); end
      checks++; if (occ_n !== e.occ) begin errors++; $display("[TB] FAIL no_forward c%0d occupancy got %0d want %0d", cyc, occ_n, e.occ); end
      @(posedge CLK);
      #1;
      cyc++;
    end
  endtask

  task automatic test_youngest();
    exp_t e;
    int   cyc = 0;
    do_reset();
    add(1,2,0,1,0,0,0,0,0, 0,3'b000,0,0,0);
    add(1,7,0,0,0,0,0,0,0, 0,3'b000,0,0,1);
    add(1,2,0,0,0,0,0,0,0, 0,3'b000,0,0,2);
    add(1,0,0,0,2,0,0,0,0, 0,3'b101,1,0,3);
    add(1,0,0,0,0,7,0,0,0, 0,3'b100,0,3,3);
    add(1,0,0,0,2,0,0,0,0, 0,3'b100,3,0,3);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++; if (stall_m !== e.stall) begin errors++; $display("[TB] FAIL youngest c%0d stall got %b want %b", cyc, stall_m, e.stall); end
      checks++; if (hazard_m !== e.hz) begin errors++; $display("[TB] FAIL youngest c%0d hazard got %b want %b", cyc, hazard_m, e.hz); end
      checks++; if (fwda_m !== e.fa) begin errors++; $display("[TB] FAIL youngest c%0d fwdA got %0d want %0d", cyc, fwda_m, e.fa); end
      checks++; if (fwdb_m !== e.fb) begin errors++; $display("[TB] FAIL youngest c%0d fwdB got %0d want %0d", cyc, fwdb_m, e.fb); end
      checks++; if (occ_m !== e.occ) begin errors++; $display("[TB] FAIL youngest c%0d occupancy got %0d want %0d", cyc, occ_m, e.occ); end
      @(posedge CLK);
      #1;
      cyc++;
    end
  endtask

  task automatic test_flags_hold();
    exp_t e;
    int   cyc = 0;
    do_reset();
    add(1,0,1,0,0,0,0,0,0, 0,3'b000,0,0,0);
    add(1,0,0,0,0,0,1,1,0, 1,3'b001,0,0,1);
    add(1,0,0,0,0,0,1,1,0, 1,3'b001,0,0,1);
    add(1,0,0,0,0,0,1,0,0, 1,3'b001,0,0,1);
    add(1,0,0,0,0,0,1,0,0, 1,3'b010,0,0,1);
    add(1,0,0,0,0,0,1,0,0, 1,3'b100,0,0,1);
    add(1,0,0,0,0,0,1,0,0, 0,3'b000,0,0,0);
    add(0,0,0,0,0,0,0,1,1, 0,3'b000,0,0,1);
    add(0,0,0,0,0,0,0,0,0, 0,3'b000,0,0,0);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++; if (stall_m !== e.stall) begin errors++; $display("[TB] FAIL flags_hold c%0d stall got %b want %b", cyc, stall_m, e.stall); end
      checks++; if (hazard_m !== e.hz) begin errors++; $display("[TB] FAIL flags_hold c%0d hazard got %b want %b", cyc, hazard_m, e.hz); end
      checks++; if (fwda_m !== e.fa) begin errors++; $display("[TB] FAIL flags_hold c%0d fwdA got %0d want %0d", cyc, fwda_m, e.fa); end
      checks++; if (fwdb_m !== e.fb) begin errors++; $display("[TB] FAIL flags_hold c%0d fwdB got %0d want %0d", cyc, fwdb_m, e.fb); end
      checks++; if (occ_m !== e.occ) begin errors++; $display("[TB] FAIL flags_hold c%0d occupancy got %0d want %0d", cyc, occ_m, e.occ); end
      @(posedge CLK);
      #1;
      cyc++;
    end
  endtask

  task automatic test_flush_reset();
    exp_t e;
    int   cyc = 0;
    stim_t s;
    do_reset();
    add(1,6,0,0,0,0,0,0,0, 0,3'b000,0,0,0);
    add(1,8,0,0,0,0,0,0,0, 0,3'b000,0,0,1);
    add(1,9,0,1,0,0,0,0,0, 0,3'b000,0,0,2);
    add(1,0,0,0,9,0,0,0,1, 1,3'b001,0,0,3);
    add(1,9,0,1,9,0,0,0,0, 0,3'b000,0,0,0);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++; if (stall_m !== e.stall) begin errors++; $display("[TB] FAIL flush c%0d stall got %b want %b", cyc, stall_m, e.stall); end
      checks++; if (hazard_m !== e.hz) begin errors++; $display("[TB] FAIL flush c%0d hazard got %b want %b", cyc, hazard_m, e.hz); end
      checks++; if (fwda_m !== e.fa) begin errors++; $display("[TB] FAIL flush c%0d fwdA got %0d want %0d", cyc, fwda_m, e.fa); end
      checks++; if (fwdb_m !== e.fb) begin errors++; $display("[TB] FAIL flush c%0d fwdB got %0d want %0d", cyc, fwdb_m, e.fb); end
      checks++; if (occ_m !== e.occ) begin errors++; $display("[TB] FAIL flush c%0d occupancy got %0d want %0d", cyc, occ_m, e.occ); end
      @(posedge CLK);
      #1;
      cyc++;
    end
    // s[1] now holds a load of r9; a reader of r9 stalls until reset lands.
    s = '0;
    s.v = 1'b1;
    s.a = 4'd9;
    drive(s);
    #2;
    checks++; if (stall_m !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset stall got %b want 1", stall_m); end
    checks++; if (occ_m !== 2'd1) begin errors++; $display("[TB] FAIL pre_reset occupancy got %0d want 1", occ_m); end
    RST = 1'b1;
    #1;
    checks++; if (stall_m !== 1'b0) begin errors++; $display("[TB] FAIL async_reset stall got %b want 0", stall_m); end
    checks++; if (hazard_m !== 3'b000) begin errors++; $display("[TB] FAIL async_reset hazard got %b want 000", hazard_m); end
    checks++; if (fwda_m !== 2'd0) begin errors++; $display("[TB] FAIL async_reset fwdA got %0d want 0", fwda_m); end
    checks++; if (occ_m !== 2'd0) begin errors++; $display("[TB] FAIL async_reset occupancy got %0d want 0", occ_m); end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    drive_idle();
  endtask

  initial begin
    RST = 1'b1;
    drive_idle();
    test_reset();
    test_forward();
    test_load_use();
    test_no_forward();
    test_youngest();
    test_flags_hold();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
